window_stream_fifo: RTL and testbench
=====================================

WINDOW_STREAM_FIFO -- requirements
Module: window_stream_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 420: pixels per row of the filtered stream.
REQ-002 SHALL have parameter HEIGHT, default 320: rows per frame.
REQ-003 SHALL have parameter DEPTH, default 16: FIFO entries; power of two, 4..64.
REQ-004 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset (0 = reset asserted).
REQ-006 SHALL have port din  input  8  filtered pixel from the 5x5 window stage.
REQ-007 SHALL have port blanking_in  input  1  border/blanking flag aligned with din.
REQ-008 SHALL have port validin  input  1  din/blanking_in qualifier; one pixel per high cycle.
REQ-009 SHALL have port dout  output  11  FIFO head word {sof, eol, blank, pixel[7:0]}.
REQ-010 SHALL have port out_valid  output  1  FIFO non-empty; dout meaningful.
REQ-011 SHALL have port out_ready  input  1  consumer accepts dout this cycle.
REQ-012 SHALL have port level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-013 SHALL have port overflow  output  1  sticky; a pixel was dropped because the FIFO was full.
REQ-014 SHALL have port frame_count  output  8  completed input frames, wraps 255->0.

Function
REQ-015 SHALL keep x_count (9 bit) and y_count (9 bit) tracking the position of the next input pixel; both advance only on validin=1.
REQ-016 SHALL advance x_count by 1 per validin; at x_count==WIDTH-1 it wraps to 0 and y_count advances by 1; at y_count==HEIGHT-1 with that wrap, y_count wraps to 0.
REQ-017 SHALL form the input word as sof=(x_count==0 && y_count==0), eol=(x_count==WIDTH-1), blank=blanking_in, pixel=din.
REQ-018 SHALL push the input word on each validin=1 cycle when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-019 SHALL pop the head when out_valid=1 and out_ready=1; out_ready ignored when out_valid=0.
REQ-020 SHALL be first-word-fall-through: a word pushed into an empty FIFO at edge N drives dout with out_valid=1 in the cycle after edge N.
REQ-021 SHALL output words in exact push order; dout SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022 SHALL update level as +1 on push only, -1 on pop only, unchanged on simultaneous push and pop; never exceeds DEPTH or goes below 0.
REQ-023 SHALL, on validin=1 with FIFO full and no pop, drop the pixel, set overflow=1, and still advance x_count/y_count so geometry stays aligned.
REQ-024 SHALL keep overflow at 1 until reset; it has no other clear.
REQ-025 SHALL increment frame_count on the validin cycle where x_count==WIDTH-1 and y_count==HEIGHT-1, whether or not the pixel was dropped.
REQ-026 SHALL wrap read and write pointers modulo DEPTH; full = level==DEPTH, empty = level==0.
REQ-027 SHALL drive out_valid=(level!=0); dout when out_valid=0 is don't-care.

Reset
REQ-028 SHALL, with reset=0 at a rising edge, set x_count=0, y_count=0, level=0, read/write pointers=0, overflow=0, frame_count=0, out_valid=0.
REQ-029 SHALL discard all FIFO contents on reset mid-operation; no push or pop occurs on a reset cycle regardless of validin/out_ready.
REQ-030 SHALL resume on the first edge with reset=1; the first accepted pixel carries sof=1.

Verification
REQ-031 SHALL cover: reset, then validin=1 din=0x5A blanking_in=0 one cycle, out_ready=0 -> next cycle out_valid=1, dout={1,0,0,0x5A}, level=1.
REQ-032 SHALL cover: WIDTH=4 HEIGHT=2, 8 consecutive pixels, out_ready=1 -> dout eol=1 on pixels 3 and 7, sof=1 on pixel 0 only, frame_count=1, level returns to 0.
REQ-033 SHALL cover: DEPTH=16, out_ready=0, 17 pixels -> level=16, overflow=1, 17th pixel absent; then out_ready=1 drains 16 words in order, out_valid=0 after.
REQ-034 SHALL cover: FIFO full, validin=1 and out_ready=1 same cycle -> pixel accepted, level stays 16, overflow stays 0.
REQ-035 SHALL cover: blanking_in=1 pixels -> pushed with blank=1 and din unchanged; x_count advances identically.
REQ-036 SHALL cover: reset=0 asserted with level=9 and overflow=1 -> next cycle level=0, out_valid=0, overflow=0, frame_count=0.

Source files
------------

// File: rtl/window_stream_fifo.sv
// Pixel stream FIFO for the 5x5 window stage: tags each pixel with frame-start / end-of-line flags
// from its raster position and buffers the tagged words in a first-word-fall-through FIFO.
module window_stream_fifo #(
  parameter int unsigned WIDTH  = 420,
  parameter int unsigned HEIGHT = 320,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [7:0]               din,
  input  logic                     blanking_in,
  input  logic                     validin,
  output logic [10:0]              dout,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [7:0]               frame_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullLevel = (AW + 1)'(DEPTH);

  logic [10:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic [8:0]    r_x_count;
  logic [8:0]    r_y_count;
  logic          r_overflow;
  logic [7:0]    r_frame_count;

  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_x_last;
  logic          w_y_last;
  logic          w_sof;
  logic [10:0]   w_word;

  always_comb begin
    w_full   = (r_level == FullLevel);
    w_pop    = out_valid && out_ready;
    // A full FIFO still accepts a pixel when the head leaves in the same cycle.
    w_push   = validin && (!w_full || w_pop);
    w_x_last = (r_x_count == 9'(WIDTH - 1));
    w_y_last = (r_y_count == 9'(HEIGHT - 1));
    w_sof    = (r_x_count == 9'd0) && (r_y_count == 9'd0);
    w_word   = {w_sof, w_x_last, blanking_in, din};
  end

  always_ff @(posedge clock) begin
    if (reset && w_push) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_level       <= '0;
      r_x_count     <= '0;
      r_y_count     <= '0;
      r_overflow    <= 1'b0;
      r_frame_count <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);

      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW + 1)'(1);
        2'b01:   r_level <= r_level - (AW + 1)'(1);
        default: r_level <= r_level;
      endcase

      // Geometry advances on every valid pixel, dropped or not, so flags stay aligned.
      if (validin) begin
        if (w_x_last) begin
          r_x_count <= '0;
          r_y_count <= w_y_last ? 9'd0 : r_y_count + 9'd1;
        end else begin
          r_x_count <= r_x_count + 9'd1;
        end
      end

      if (validin && w_x_last && w_y_last) r_frame_count <= r_frame_count + 8'd1;
      if (validin && w_full && !w_pop)     r_overflow    <= 1'b1;
    end
  end

  assign dout        = r_mem[r_rd_ptr];
  assign out_valid   = (r_level != '0);
  assign level       = r_level;
  assign overflow    = r_overflow;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_window_stream_fifo.sv
// Directed bench for window_stream_fifo on a 4x2 frame with a 16-entry FIFO: a per-cycle vector
// table for tagging and fall-through behaviour, plus hand sequences for full/overflow/reset cases.
module tb_window_stream_fifo;

  localparam int unsigned W = 4;
  localparam int unsigned H = 2;
  localparam int unsigned D = 16;

  logic        clock;
  logic        reset;
  logic [7:0]  din;
  logic        blanking_in;
  logic        validin;
  logic [10:0] dout;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  level;
  logic        overflow;
  logic [7:0]  frame_count;

  int n_checks = 0;
  int n_errors = 0;

  window_stream_fifo #(
    .WIDTH (W),
    .HEIGHT(H),
    .DEPTH (D)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .din        (din),
    .blanking_in(blanking_in),
    .validin    (validin),
    .dout       (dout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .level      (level),
    .overflow   (overflow),
    .frame_count(frame_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        vin;
    logic [7:0]  d;
    logic        blk;
    logic        rdy;
    logic        ev;
    logic [10:0] edout;
    int unsigned elevel;
    int unsigned eframe;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic cyc(input logic v, input logic [7:0] d, input logic b, input logic r);
    validin     = v;
    din         = d;
    blanking_in = b;
    out_ready   = r;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    reset = 1'b1;
  endtask

  initial begin
    reset       = 1'b0;
    validin     = 1'b0;
    din         = 8'h00;
    blanking_in = 1'b0;
    out_ready   = 1'b0;

    // {vin, din, blank, ready, exp_valid, exp_dout {sof,eol,blank,pix}, exp_level, exp_frame}
    vecs[0]  = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 11'h45A, 1, 0};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 11'h000, 0, 0};
    vecs[2]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 11'h011, 1, 0};
    vecs[3]  = '{1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 11'h122, 1, 0};
    vecs[4]  = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 11'h233, 1, 0};
    vecs[5]  = '{1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 11'h144, 1, 0};
    vecs[6]  = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 11'h055, 1, 0};
    vecs[7]  = '{1'b1, 8'h66, 1'b0, 1'b1, 1'b1, 11'h066, 1, 0};
    vecs[8]  = '{1'b1, 8'h77, 1'b1, 1'b1, 1'b1, 11'h377, 1, 1};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 11'h000, 0, 1};
    vecs[10] = '{1'b1, 8'h88, 1'b0, 1'b0, 1'b1, 11'h488, 1, 1};
    vecs[11] = '{1'b1, 8'h99, 1'b0, 1'b0, 1'b1, 11'h488, 2, 1};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 11'h488, 2, 1};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 11'h099, 1, 1};
    vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 11'h000, 0, 1};

    // Reset state
    cyc(1'b1, 8'hFF, 1'b1, 1'b1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_frame", 32'(frame_count), 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 15; i++) begin
      cyc(vecs[i].vin, vecs[i].d, vecs[i].blk, vecs[i].rdy);
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].ev));
      if (vecs[i].ev) chk($sformatf("vec%0d_dout", i), 32'(dout), 32'(vecs[i].edout));
      chk($sformatf("vec%0d_level", i), 32'(level), vecs[i].elevel);
      chk($sformatf("vec%0d_frame", i), 32'(frame_count), vecs[i].eframe);
    end

    // Fill past full: 17th pixel is dropped, overflow sticks.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      cyc(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 15) begin
        chk("fill16_level", 32'(level), 32'd16);
        chk("fill16_overflow", 32'(overflow), 32'd0);
      end
    end
    chk("ovf_level", 32'(level), 32'd16);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_frame", 32'(frame_count), 32'd2);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("drain%0d_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("drain%0d_dout", k), 32'(dout),
          32'({(k % 8) == 0, (k % 4) == 3, 1'b0, 8'(k)}));
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
    end
    chk("drained_valid", 32'(out_valid), 32'd0);
    chk("drained_level", 32'(level), 32'd0);
    chk("drained_overflow", 32'(overflow), 32'd1);
    // Dropped pixel still advanced geometry: next pixel sits at x=1, y=0.
    cyc(1'b1, 8'hAB, 1'b0, 1'b0);
    chk("post_drop_dout", 32'(dout), 32'h0AB);

    // Full FIFO with simultaneous push and pop.
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'h40, 1'b0, 1'b1);
    chk("fullpp_level", 32'(level), 32'd16);
    chk("fullpp_overflow", 32'(overflow), 32'd0);
    chk("fullpp_head", 32'(dout), 32'h021);
    cyc(1'b1, 8'h41, 1'b0, 1'b0);
    chk("fullpp_drop_ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 7; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("pre_rst_level", 32'(level), 32'd9);
    chk("pre_rst_overflow", 32'(overflow), 32'd1);
    chk("pre_rst_frame", 32'(frame_count), 32'd2);

    // Mid-operation reset with active push/pop requests.
    reset = 1'b0;
    cyc(1'b1, 8'h77, 1'b0, 1'b1);
    reset = 1'b1;
    chk("midrst_level", 32'(level), 32'd0);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_overflow", 32'(overflow), 32'd0);
    chk("midrst_frame", 32'(frame_count), 32'd0);
    cyc(1'b1, 8'h3C, 1'b1, 1'b0);
    chk("resume_dout", 32'(dout), 32'h53C);
    chk("resume_level", 32'(level), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
